// File: rtl/sipo_defs.sv
// Shared definitions for the serial-in / parallel-out loader.
// Holds the controller state encoding and the default word width and
// bit-order settings used by sipo_loader and sipo_ctrl.
package sipo_defs;

   localparam int DEF_WIDTH     = 4;
   localparam bit DEF_MSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

endpackage

// File: rtl/sipo_ctrl.sv
// Frame controller for sipo_loader: three-state FSM plus bit counter.
// Ports:
//   clk, clear_n     clock, asynchronous active-low reset
//   i_sin_valid      serial bit qualifier
//   i_start          marks the qualified bit as bit 0 of a new frame
//   o_capture        comb: the current qualified bit is accepted this edge
//   o_first          comb: the accepted bit is bit 0 (partial word restarts)
//   o_complete       comb: the accepted bit is the last bit of the word
//   o_busy           registered: frame partially received
//   o_load           registered: one-cycle pulse after a completed word
//   o_frame_err      registered: one-cycle pulse after an aborted frame
module sipo_ctrl
   import sipo_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic clk,
   input  logic clear_n,
   input  logic i_sin_valid,
   input  logic i_start,
   output logic o_capture,
   output logic o_first,
   output logic o_complete,
   output logic o_busy,
   output logic o_load,
   output logic o_frame_err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t          r_state, w_state_next;
   logic [CW-1:0]   r_count, w_count_next;
   logic            w_abort;
   logic            r_busy, r_load, r_frame_err;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_busy      <= 1'b0;
         r_load      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_count     <= w_count_next;
         // Status outputs are decoded from the next state so they are
         // flop outputs aligned with the state they describe.
         r_busy      <= (w_state_next == ST_SHIFT);
         r_load      <= (w_state_next == ST_LOAD);
         r_frame_err <= w_abort;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      o_capture    = 1'b0;
      o_first      = 1'b0;
      o_complete   = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE, ST_LOAD: begin
            // A start in the LOAD cycle chains frames without losing a bit.
            if (i_sin_valid && i_start) begin
               o_capture    = 1'b1;
               o_first      = 1'b1;
               w_count_next = CW'(1);
               w_state_next = ST_SHIFT;
            end else begin
               w_count_next = '0;
               w_state_next = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (i_sin_valid) begin
               o_capture = 1'b1;
               if (i_start) begin
                  // Restart: partial frame is dropped, this bit becomes bit 0.
                  o_first      = 1'b1;
                  w_abort      = 1'b1;
                  w_count_next = CW'(1);
               end else if (r_count == CW'(WIDTH - 1)) begin
                  o_complete   = 1'b1;
                  w_count_next = '0;
                  w_state_next = ST_LOAD;
               end else begin
                  w_count_next = r_count + CW'(1);
               end
            end
         end
         default: begin
            w_count_next = '0;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign o_busy      = r_busy;
   assign o_load      = r_load;
   assign o_frame_err = r_frame_err;

endmodule

// File: rtl/sipo_loader.sv
// Serial-in / parallel-out loader: assembles WIDTH serial bits into a word
// and presents it on par_out with a one-cycle load strobe for a downstream
// register.
// Ports:
//   clk, clear_n     clock, asynchronous active-low reset
//   sin, sin_valid   serial bit and its qualifier
//   start            marks the qualified bit as bit 0 of a new frame
//   par_out          last completed word (registered)
//   load             one-cycle pulse when par_out has just been updated
//   busy             frame partially received
//   frame_err        one-cycle pulse when a partial frame was aborted
module sipo_loader
   import sipo_defs::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = DEF_MSB_FIRST
)(
   input  logic             clk,
   input  logic             clear_n,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             start,
   output logic [WIDTH-1:0] par_out,
   output logic             load,
   output logic             busy,
   output logic             frame_err
);

   // Only WIDTH-1 bits need storing: the last bit goes straight from sin
   // into the completed word.
   localparam int PW = WIDTH - 1;

   logic [PW-1:0]    r_part;
   logic [PW-1:0]    w_base, w_part_next;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH-1:0] r_par;
   logic             w_capture, w_first, w_complete;

   sipo_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk         (clk),
      .clear_n     (clear_n),
      .i_sin_valid (sin_valid),
      .i_start     (start),
      .o_capture   (w_capture),
      .o_first     (w_first),
      .o_complete  (w_complete),
      .o_busy      (busy),
      .o_load      (load),
      .o_frame_err (frame_err)
   );

   // A new frame starts from an empty partial word.
   assign w_base = w_first ? '0 : r_part;

   // MSB-first shifts toward the top so bit 0 lands in par_out[WIDTH-1];
   // LSB-first shifts toward the bottom so bit 0 lands in par_out[0].
   generate
      for (genvar gi = 0; gi < PW; gi++) begin : g_bit
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_in
               assign w_part_next[gi] = sin;
            end else begin : g_sh
               assign w_part_next[gi] = w_base[gi-1];
            end
         end else begin : g_lsb
            if (gi == PW - 1) begin : g_in
               assign w_part_next[gi] = sin;
            end else begin : g_sh
               assign w_part_next[gi] = w_base[gi+1];
            end
         end
      end
      if (MSB_FIRST) begin : g_word_msb
         assign w_word = {w_base, sin};
      end else begin : g_word_lsb
         assign w_word = {sin, w_base};
      end
   endgenerate

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_part <= '0;
         r_par  <= '0;
      end else begin
         if (w_capture && !w_complete) r_part <= w_part_next;
         // par_out only moves on a completed frame; aborts leave it alone.
         if (w_complete)               r_par  <= w_word;
      end
   end

   assign par_out = r_par;

endmodule

// File: tb/tb_sipo_loader.sv
module tb_sipo_loader;

   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic       sin = 1'b0;
   logic       sin_valid = 1'b0;
   logic       start = 1'b0;
   logic [3:0] par_m, par_l;
   logic       load_m, busy_m, ferr_m;
   logic       load_l, busy_l, ferr_l;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int busy_cnt = 0;
   int err_cnt  = 0;

   typedef struct {
      logic [3:0] m;
      logic [3:0] l;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sipo_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .clear_n(clear_n), .sin(sin), .sin_valid(sin_valid),
      .start(start), .par_out(par_m), .load(load_m), .busy(busy_m),
      .frame_err(ferr_m)
   );

   sipo_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .clear_n(clear_n), .sin(sin), .sin_valid(sin_valid),
      .start(start), .par_out(par_l), .load(load_l), .busy(busy_l),
      .frame_err(ferr_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs; they are captured on the next rising edge.
   task automatic bit_cyc(input logic s, input logic st, input logic v);
      sin = s;
      start = st;
      sin_valid = v;
      @(posedge clk);
      #1;
      sin_valid = 1'b0;
      start = 1'b0;
   endtask

   // seq[3] is sent first (with start). Expected words are hand-computed.
   task automatic send_frame(input logic [3:0] seq, input logic [3:0] exp_m,
                             input logic [3:0] exp_l, input int max_gap);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (i > 0 && max_gap > 0)
            repeat ($urandom_range(0, max_gap)) bit_cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         if (i == 3) begin
            e.m = exp_m;
            e.l = exp_l;
            e.cyc = cyc + 1;
            sb.push_back(e);
         end
         bit_cyc(seq[3-i], (i == 0), 1'b1);
      end
   endtask

   // Monitor: pops the scoreboard whenever a load strobe appears.
   always @(negedge clk) begin
      if (clear_n) begin
         if (busy_m) busy_cnt++;
         if (ferr_m) err_cnt++;
         chk("load_m_vs_load_l", {31'd0, load_l}, {31'd0, load_m});
         if (load_m && ferr_m) chk("load_ferr_overlap", 32'd1, 32'd0);
         if (load_m) begin
            if (sb.size() == 0) begin
               chk("unexpected_load", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               $display("LOAD cyc=%0d par_m=%b (exp %b) par_l=%b (exp %b)",
                        cyc, par_m, e.m, par_l, e.l);
               chk("par_out_msb", {28'd0, par_m}, {28'd0, e.m});
               chk("par_out_lsb", {28'd0, par_l}, {28'd0, e.l});
               chk("load_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int b0;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_par_m", {28'd0, par_m}, 32'd0);
      chk("rst_outs", {29'd0, load_m, busy_m, ferr_m}, 32'd0);
      clear_n = 1'b1;

      // Basic frame 1,0,1,1: MSB-first 1011, LSB-first 1101; busy 3 cycles
      b0 = busy_cnt;
      send_frame(4'b1011, 4'b1011, 4'b1101, 0);
      bit_cyc(1'b0, 1'b0, 1'b0);
      bit_cyc(1'b0, 1'b0, 1'b0);
      chk("busy_cycles", busy_cnt - b0, 32'd3);

      // Abort: 1,0 then restart with 0,1,1,0
      bit_cyc(1'b1, 1'b1, 1'b1);
      bit_cyc(1'b0, 1'b0, 1'b1);
      chk("par_hold_partial", {28'd0, par_m}, {28'd0, 4'b1011});
      bit_cyc(1'b0, 1'b1, 1'b1);
      chk("frame_err_pulse", {30'd0, ferr_m, busy_m}, 32'd3);
      chk("par_hold_abort", {28'd0, par_m}, {28'd0, 4'b1011});
      bit_cyc(1'b1, 1'b0, 1'b1);
      chk("frame_err_clear", {31'd0, ferr_m}, 32'd0);
      bit_cyc(1'b1, 1'b0, 1'b1);
      begin
         exp_t e;
         e.m = 4'b0110;
         e.l = 4'b0110;
         e.cyc = cyc + 1;
         sb.push_back(e);
      end
      bit_cyc(1'b0, 1'b0, 1'b1);
      bit_cyc(1'b0, 1'b0, 1'b0);

      // Back-to-back: 1010 then start in the LOAD cycle with 0011
      send_frame(4'b1010, 4'b1010, 4'b0101, 0);
      send_frame(4'b0011, 4'b0011, 4'b1100, 0);
      // Valid bit without start during LOAD is ignored
      bit_cyc(1'b1, 1'b0, 1'b1);
      chk("load_ignore_busy", {31'd0, busy_m}, 32'd0);
      bit_cyc(1'b0, 1'b0, 1'b0);

      // Frame 1100 with random sin_valid gaps of 0-3 cycles
      send_frame(4'b1100, 4'b1100, 4'b0011, 3);
      repeat (2) bit_cyc(1'b0, 1'b0, 1'b0);
      send_frame(4'b0101, 4'b0101, 4'b1010, 3);
      repeat (2) bit_cyc(1'b0, 1'b0, 1'b0);

      // Reset after 3 bits of a frame
      bit_cyc(1'b1, 1'b1, 1'b1);
      bit_cyc(1'b1, 1'b0, 1'b1);
      bit_cyc(1'b1, 1'b0, 1'b1);
      chk("pre_reset_busy", {31'd0, busy_m}, 32'd1);
      clear_n = 1'b0;
      #2;
      chk("async_rst_par_m", {28'd0, par_m}, 32'd0);
      chk("async_rst_par_l", {28'd0, par_l}, 32'd0);
      chk("async_rst_outs", {29'd0, load_m, busy_m, ferr_m}, 32'd0);
      @(posedge clk);
      #1;
      clear_n = 1'b1;
      b0 = busy_cnt;
      repeat (4) bit_cyc(1'b1, 1'b0, 1'b1);
      repeat (2) bit_cyc(1'b0, 1'b0, 1'b0);
      chk("no_start_ignored", busy_cnt - b0, 32'd0);
      chk("post_rst_par", {28'd0, par_m}, 32'd0);

      chk("scoreboard_drained", sb.size(), 32'd0);
      chk("frame_err_count", err_cnt, 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
